uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one UART serial transmitter among NUM_REQ requesters.
- Each requester offers one 16-bit message; the scheduler picks a winner and latches its data.
- It launches the transmitter and waits for frame completion.
- It then enforces an idle line gap so the far-end receiver's edge-based resync sees a clean idle between frames.
- Sits between on-chip producers (sensor/status blocks) and the UART transmit datapath.

---
 rtl/uart_tx_scheduler_pkg.sv | 8 +
 rtl/uart_tx_scheduler_rr_picker.sv | 33 +++
 rtl/uart_tx_scheduler.sv | 85 ++++++++
 tb/tb_uart_tx_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// uart_sched_pkg: shared state type, default message width and index wrap helper for the UART scheduler
package uart_sched_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} sched_state_t;
  localparam int DEF_MSG_W = 16;
  function automatic int next_index(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/uart_tx_scheduler_rr_picker.sv
// rr_picker: rotating-priority request search with a pointer that moves just past each granted index
module rr_picker
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  input  logic [IW-1:0]      i_winner,
  output logic [IW-1:0]      o_pick,
  output logic               o_any_req
);
  localparam logic [IW:0] LIM = (IW+1)'(NUM_REQ);
  logic [IW-1:0]      r_ptr;
  logic [NUM_REQ-1:0] w_rot;
  logic [IW-1:0]      w_off;
  logic [IW:0]        w_sum;
  assign w_rot = NUM_REQ'({i_req, i_req} >> r_ptr);
  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (w_rot[k]) w_off = IW'(k);
  end
  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
  assign o_pick    = (w_sum >= LIM) ? IW'(w_sum - LIM) : IW'(w_sum);
  assign o_any_req = |i_req;
  always_ff @(posedge i_clock)
    if (i_reset) r_ptr <= '0;
    else if (i_advance) r_ptr <= IW'(next_index(int'(i_winner), NUM_REQ));
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART transmitter, with launch, done/timeout wait and idle line gap
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int MSG_W          = DEF_MSG_W,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*MSG_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [MSG_W-1:0]         o_tx_message,
  output logic                     o_tx_start,
  input  logic                     i_tx_busy,
  input  logic                     i_tx_done,
  output logic [IW-1:0]            o_active_id,
  output logic                     o_sched_busy,
  output logic                     o_timeout_err,
  input  logic                     i_clear_err
);
  localparam int TMAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  sched_state_t     r_state;
  sched_state_t     w_next;
  logic [MSG_W-1:0] r_msg;
  logic [IW-1:0]    r_id;
  logic [TW-1:0]    r_timer;
  logic             r_err;
  logic [IW-1:0]    w_pick;
  logic             w_any;
  logic             w_launch;
  logic             w_done;
  logic             w_timeout;
  logic             w_gap_end;
  logic [MSG_W-1:0] w_slices [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign w_slices[i] = i_req_data[i*MSG_W +: MSG_W];
  end
  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_req     (i_req),
    .i_advance (r_state == LAUNCH),
    .i_winner  (r_id),
    .o_pick    (w_pick),
    .o_any_req (w_any)
  );
  assign w_launch  = (r_state == IDLE) && w_any && !i_tx_busy;
  assign w_done    = (r_state == WAIT) && i_tx_done;
  assign w_timeout = (r_state == WAIT) && !i_tx_done && (r_timer == TO_LAST);
  assign w_gap_end = (r_state == GAP) && (r_timer == GAP_LAST);
  always_comb
    w_next = (r_state == LAUNCH)    ? WAIT :
             w_launch               ? LAUNCH :
             (w_done || w_timeout)  ? ((GAP_CYCLES == 0) ? IDLE : GAP) :
             w_gap_end              ? IDLE : r_state;
  always_ff @(posedge i_clock)
    if (i_reset) begin
      r_state <= IDLE;
      r_msg   <= '0;
      r_id    <= '0;
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_timer <= (r_state != w_next || r_state == IDLE) ? '0 : r_timer + 1'b1;
      if (w_launch) begin
        r_msg <= w_slices[w_pick];
        r_id  <= w_pick;
      end
      r_err <= w_timeout | (r_err & ~i_clear_err);
    end
  assign o_tx_start    = (r_state == LAUNCH);
  assign o_grant       = o_tx_start ? (NUM_REQ'(1) << r_id) : '0;
  assign o_tx_message  = r_msg;
  assign o_active_id   = r_id;
  assign o_sched_busy  = (r_state != IDLE);
  assign o_timeout_err = r_err;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: scoreboard bench; a pending-set/pointer model predicts each launch, a monitor checks it
module tb_uart_tx_scheduler;
  localparam int N = 4, W = 16, GAP = 16, TO = 4096;
  typedef struct { int id; logic [W-1:0] msg; int cyc; } exp_t;
  logic clk = 0, rst = 1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] req_data = '0;
  logic tx_busy = 0, tx_done = 0, clear_err = 0;
  logic [N-1:0] grant;
  logic [W-1:0] tx_message;
  logic tx_start, sched_busy, timeout_err;
  logic [1:0] active_id;
  exp_t q[$];
  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [W-1:0] dat [N];
  logic [N-1:0] pend = '0;
  int mptr = 0, last_win = 0, last_act = 0, lcyc = 0, dcyc = 0, free_cyc = 0;
  logic [W-1:0] last_msg = '0;

  uart_tx_scheduler #(.NUM_REQ(N), .MSG_W(W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_req_data(req_data),
    .o_grant(grant), .o_tx_message(tx_message), .o_tx_start(tx_start),
    .i_tx_busy(tx_busy), .i_tx_done(tx_done), .o_active_id(active_id),
    .o_sched_busy(sched_busy), .o_timeout_err(timeout_err), .i_clear_err(clear_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) if (pend[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction

  task automatic expect_next(input int at);
    int w;
    w = pick();
    q.push_back('{w, dat[w], at});
    last_win = w;
    mptr = (w + 1) % N;
  endtask

  task automatic add_one(input int i, input logic [W-1:0] v);
    dat[i] = v;
    req_data[i*W +: W] = v;
    pend[i] = 1'b1;
    req[i] = 1'b1;
  endtask

  task automatic add(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) if (mask[i] && !pend[i]) add_one(i, W'($urandom));
  endtask

  task automatic idle_req(input logic [N-1:0] mask);
    add(mask);
    expect_next(cyc + 1);
  endtask

  task automatic do_reset(input bit clr);
    rst = 1; tx_done = 0; tx_busy = 0; clear_err = 0;
    if (clr) begin req = '0; pend = '0; end
    q.delete();
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_message", tx_message, 0);
    chk("rst_active_id", active_id, 0);
    chk("rst_sched_busy", sched_busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    tick();
    rst = 0;
    mptr = 0;
    if (pend != 0) expect_next(cyc + 1);
  endtask

  task automatic wait_launch();
    int t;
    t = 0;
    while (!tx_start && t < 300) begin tick(); t++; end
    if (!tx_start) begin
      n_cmp++; n_err++;
      $display("FAIL launch_wait: no tx_start within 300 cycles, expected requester %0d", last_win);
    end
    last_act = int'(active_id);
    lcyc = cyc;
    req[last_win] = 1'b0;
    pend[last_win] = 1'b0;
  endtask

  task automatic finish_frame(input int dly, input logic [N-1:0] mask, input bit rnd, input int busy_k);
    for (int k = 1; k <= dly; k++) begin
      tick();
      if (k == 1) add(mask);
      if (rnd && $urandom_range(0, 2) == 0) add(N'(1) << $urandom_range(0, N - 1));
    end
    dcyc = cyc;
    if (dly < TO) tx_done = 1;
    free_cyc = dcyc + GAP + 1;
    if (dcyc + busy_k + 1 > free_cyc) free_cyc = dcyc + busy_k + 1;
    if (pend != 0) expect_next(free_cyc + 1);
    tick();
    tx_done = 0;
    tx_busy = (busy_k > 0);
    for (int k = 2; k <= busy_k; k++) tick();
    if (busy_k > 0) begin tick(); tx_busy = 0; end
  endtask

  always @(negedge clk) begin
    if (tx_start) begin
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_launch: tx_start for id %0d with nothing expected (cycle %0d)", active_id, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("launch_grant", grant, N'(1) << e.id);
        chk("launch_id", active_id, e.id);
        chk("launch_msg", tx_message, e.msg);
        chk("launch_cycle", cyc, e.cyc);
        chk("launch_busy", sched_busy, 1);
        last_msg = e.msg;
      end
    end else begin
      chk("grant_idle", grant, 0);
      if (sched_busy) chk("msg_hold", tx_message, last_msg);
    end
  end

  initial begin
    int order [6] = '{0, 1, 2, 3, 0, 1};
    int l_prev, target;
    l_prev = 0;
    add(4'hF);
    do_reset(0);
    for (int f = 0; f < 6; f++) begin
      wait_launch();
      chk("rr_order", last_act, order[f]);
      if (f > 0) chk("rr_spacing", lcyc - l_prev, 10 + GAP + 2);
      l_prev = lcyc;
      finish_frame(10, 4'hF, 0, 0);
    end
    do_reset(1);
    add_one(2, 16'hA55A);
    expect_next(cyc + 1);
    wait_launch();
    chk("single_id", last_act, 2);
    chk("single_msg", tx_message, 16'hA55A);
    finish_frame(20, 4'h0, 0, 0);
    for (int k = 1; k <= GAP; k++) begin chk("gap_busy", sched_busy, 1); tick(); end
    chk("gap_idle", sched_busy, 0);
    idle_req(4'b0010);
    wait_launch();
    chk("wrap_setup", last_act, 1);
    finish_frame(15, 4'b1010, 0, 0);
    wait_launch();
    chk("wrap_first", last_act, 3);
    finish_frame(15, 4'h0, 0, 0);
    wait_launch();
    chk("wrap_second", last_act, 1);
    finish_frame(15, 4'h0, 0, 0);
    while (cyc < free_cyc) tick();
    tx_busy = 1;
    add(4'b0001);
    for (int k = 0; k < 10; k++) begin tick(); chk("busy_hold", tx_start, 0); end
    tx_busy = 0;
    expect_next(cyc + 1);
    wait_launch();
    chk("busy_release_id", last_act, 0);
    finish_frame(12, 4'h0, 0, 0);
    while (cyc < free_cyc) tick();
    idle_req(4'b0100);
    wait_launch();
    chk("err_before", timeout_err, 0);
    finish_frame(TO, 4'b0001, 0, 0);
    chk("timeout_set", timeout_err, 1);
    wait_launch();
    chk("timeout_next", last_act, 0);
    repeat (5) tick();
    add(4'hF);
    do_reset(0);
    wait_launch();
    chk("reset_ptr", last_act, 0);
    finish_frame(TO, 4'h0, 0, 0);
    chk("timeout_set2", timeout_err, 1);
    clear_err = 1;
    tick();
    clear_err = 0;
    chk("clear_err", timeout_err, 0);
    for (int f = 0; f < 40; f++) begin
      wait_launch();
      finish_frame($urandom_range(1, 40), 4'h0, 1, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0);
      if (pend == 0) begin
        target = free_cyc + $urandom_range(0, 3);
        while (cyc < target) tick();
        idle_req(N'($urandom_range(1, 15)));
      end
    end
    while (pend != 0) begin
      wait_launch();
      finish_frame(5, 4'h0, 0, 0);
    end
    repeat (GAP + 5) tick();
    chk("queue_drained", q.size(), 0);
    chk("final_idle", sched_busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
